// File: rtl/fejkon_pcie_tx_arb.sv
// ----------------------------------------------------------------------------
// fejkon_pcie_tx_arb: packet-locked round-robin arbiter of CplD (s0) and MWr (s1) onto PCIe TX
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fejkon_pcie_tx_arb #(
  parameter int DATA_W       = 256,
  parameter int EMPTY_W      = 2,
  parameter int CNT_W        = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  s0_data,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic               s0_startofpacket,
  input  logic               s0_endofpacket,
  input  logic [EMPTY_W-1:0] s0_empty,
  input  logic [DATA_W-1:0]  s1_data,
  input  logic               s1_valid,
  output logic               s1_ready,
  input  logic               s1_startofpacket,
  input  logic               s1_endofpacket,
  input  logic [EMPTY_W-1:0] s1_empty,
  output logic [DATA_W-1:0]  tx_st_data,
  output logic               tx_st_valid,
  input  logic               tx_st_ready,
  output logic               tx_st_startofpacket,
  output logic               tx_st_endofpacket,
  output logic [EMPTY_W-1:0] tx_st_empty,
  output logic               tx_st_error,
  output logic [CNT_W-1:0]   cnt_s0_pkts,
  output logic [CNT_W-1:0]   cnt_s1_pkts,
  output logic [15:0]        cnt_proto_err
);

  localparam int RUN_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STARVE_LIMIT);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [RUN_W-1:0] s1_run_q, s1_run_d;
  logic [CNT_W-1:0] cnt_s0_q, cnt_s0_d;
  logic [CNT_W-1:0] cnt_s1_q, cnt_s1_d;
  logic [15:0]      err_q, err_d;

  logic             cand0, cand1;
  logic [16:0]      err_sum;

  always_comb begin
    state_d             = state_q;
    last_grant_d        = last_grant_q;
    s1_run_d            = s1_run_q;
    cnt_s0_d            = cnt_s0_q;
    cnt_s1_d            = cnt_s1_q;
    err_d               = err_q;
    s0_ready            = 1'b0;
    s1_ready            = 1'b0;
    tx_st_data          = '0;
    tx_st_valid         = 1'b0;
    tx_st_startofpacket = 1'b0;
    tx_st_endofpacket   = 1'b0;
    tx_st_empty         = '0;
    cand0               = s0_valid & s0_startofpacket;
    cand1               = s1_valid & s1_startofpacket;
    err_sum             = '0;

    case (state_q)
      IDLE: begin
        // Beats without sop outside a packet can never be framed; swallow and count them.
        s0_ready = s0_valid & ~s0_startofpacket;
        s1_ready = s1_valid & ~s1_startofpacket;
        err_sum  = {1'b0, err_q} + {16'd0, s0_ready} + {16'd0, s1_ready};
        err_d    = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (cand0 && cand1) begin
          state_d = ((s1_run_q >= RUN_MAX) || last_grant_q) ? GRANT0 : GRANT1;
        end else if (cand0) begin
          state_d = GRANT0;
        end else if (cand1) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        tx_st_data          = s0_data;
        tx_st_valid         = s0_valid;
        tx_st_startofpacket = s0_startofpacket;
        tx_st_endofpacket   = s0_endofpacket;
        tx_st_empty         = s0_empty;
        s0_ready            = tx_st_ready;
        if (s0_valid && tx_st_ready && s0_endofpacket) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          cnt_s0_d     = cnt_s0_q + CNT_W'(1);
          s1_run_d     = '0;
        end
      end
      GRANT1: begin
        tx_st_data          = s1_data;
        tx_st_valid         = s1_valid;
        tx_st_startofpacket = s1_startofpacket;
        tx_st_endofpacket   = s1_endofpacket;
        tx_st_empty         = s1_empty;
        s1_ready            = tx_st_ready;
        if (s1_valid && tx_st_ready && s1_endofpacket) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          cnt_s1_d     = cnt_s1_q + CNT_W'(1);
          s1_run_d     = (s1_run_q >= RUN_MAX) ? RUN_MAX : s1_run_q + RUN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      s1_run_q     <= '0;
      cnt_s0_q     <= '0;
      cnt_s1_q     <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      s1_run_q     <= s1_run_d;
      cnt_s0_q     <= cnt_s0_d;
      cnt_s1_q     <= cnt_s1_d;
      err_q        <= err_d;
    end
  end

  assign tx_st_error   = 1'b0;
  assign cnt_s0_pkts   = cnt_s0_q;
  assign cnt_s1_pkts   = cnt_s1_q;
  assign cnt_proto_err = err_q;

endmodule

`default_nettype wire
